// File: rtl/utim64_irq_scheduler_if.sv
// rtl/utim64_irq_scheduler_if.sv - request/acknowledge bus between scheduler and interrupt controller
interface utim64_irq_scheduler_if #(
    parameter int P_CH_W = 2
) ();
    logic              oIRQ_VALID;
    logic [P_CH_W-1:0] oIRQ_NUM;
    logic              iIRQ_ACK;

    modport master (
        output oIRQ_VALID,
        output oIRQ_NUM,
        input  iIRQ_ACK
    );

    modport slave (
        input  oIRQ_VALID,
        input  oIRQ_NUM,
        output iIRQ_ACK
    );
endinterface

// File: rtl/utim64_irq_scheduler.sv
// rtl/utim64_irq_scheduler.sv - round-robin IRQ edge scheduler, optional channel mask via UTIM64_IRQ_MASK_EN
module utim64_irq_scheduler #(
    parameter int P_CH_N = 4,
    parameter int P_CH_W = 2
) (
    input  logic              iCLOCK,
    input  logic              inRESET,
    input  logic              iSCHED_ENA,
    input  logic [P_CH_N-1:0] iIRQ_SRC,
    input  logic              iCLEAR,
    input  logic [P_CH_N-1:0] iCLEAR_SEL,
`ifdef UTIM64_IRQ_MASK_EN
    input  logic              iMASK_WRITE,
    input  logic [P_CH_N-1:0] iMASK_DATA,
`endif
    utim64_irq_scheduler_if.master irq_bus,
    output logic [P_CH_N-1:0] oPENDING,
    output logic [P_CH_N-1:0] oOVERRUN
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [P_CH_W-1:0]   r_num;
    logic [P_CH_W-1:0]   w_num_nxt;
    logic [P_CH_W-1:0]   r_last;
    logic [P_CH_W-1:0]   w_last_nxt;
    logic [P_CH_N-1:0]   r_prev;
    logic [P_CH_N-1:0]   r_pending;
    logic [P_CH_N-1:0]   w_pending_nxt;
    logic [P_CH_N-1:0]   r_overrun;
    logic [P_CH_N-1:0]   w_overrun_nxt;
    logic [P_CH_N-1:0]   w_rise;
    logic [P_CH_N-1:0]   w_eligible;
    logic [P_CH_N-1:0]   w_consumed;
    logic                w_ack_fire;
    logic                w_found;
    logic [P_CH_W-1:0]   w_pick;

    assign w_rise     = iIRQ_SRC & ~r_prev;
    assign w_ack_fire = (r_state == ST_REQ) && irq_bus.iIRQ_ACK;

`ifdef UTIM64_IRQ_MASK_EN
    logic [P_CH_N-1:0] r_mask;

    // Mask register: a set bit removes the channel from arbitration only.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            r_mask <= '0;
        end else if (iMASK_WRITE) begin
            r_mask <= iMASK_DATA;
        end
    end

    assign w_eligible = r_pending & ~r_mask;
`else
    assign w_eligible = r_pending;
`endif

    // Round-robin search starting at the channel after the last granted one.
    always_comb begin
        int v_idx;
        v_idx   = 0;
        w_found = 1'b0;
        w_pick  = '0;
        for (int k = 1; k <= P_CH_N; k++) begin
            v_idx = (int'(r_last) + k) % P_CH_N;
            if (!w_found && w_eligible[v_idx]) begin
                w_found = 1'b1;
                w_pick  = P_CH_W'(v_idx);
            end
        end
    end

    // Pending/overrun update; a same-cycle rise beats both clear and consumption.
    always_comb begin
        w_consumed    = '0;
        w_pending_nxt = r_pending;
        w_overrun_nxt = r_overrun;
        if (w_ack_fire) begin
            w_consumed[r_num] = 1'b1;
        end
        for (int i = 0; i < P_CH_N; i++) begin
            if (w_rise[i]) begin
                w_pending_nxt[i] = 1'b1;
                if (!(iCLEAR && iCLEAR_SEL[i]) && r_pending[i] && !w_consumed[i]) begin
                    w_overrun_nxt[i] = 1'b1;
                end
            end else if (iCLEAR && iCLEAR_SEL[i]) begin
                w_pending_nxt[i] = 1'b0;
                w_overrun_nxt[i] = 1'b0;
            end else if (w_consumed[i]) begin
                w_pending_nxt[i] = 1'b0;
            end
        end
    end

    // Scheduler next-state: grant from IDLE, hold the request until acknowledged.
    always_comb begin
        w_state_nxt = r_state;
        w_num_nxt   = r_num;
        w_last_nxt  = r_last;
        case (r_state)
            ST_IDLE: begin
                if (iSCHED_ENA && w_found) begin
                    w_state_nxt = ST_REQ;
                    w_num_nxt   = w_pick;
                end
            end
            ST_REQ: begin
                if (irq_bus.iIRQ_ACK) begin
                    w_state_nxt = ST_IDLE;
                    w_last_nxt  = r_num;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State registers; last-grant resets to the top channel so channel 0 wins first.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            r_state   <= ST_IDLE;
            r_num     <= '0;
            r_last    <= P_CH_W'(P_CH_N - 1);
            r_prev    <= '0;
            r_pending <= '0;
            r_overrun <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_num     <= w_num_nxt;
            r_last    <= w_last_nxt;
            r_prev    <= iIRQ_SRC;
            r_pending <= w_pending_nxt;
            r_overrun <= w_overrun_nxt;
        end
    end

    assign irq_bus.oIRQ_VALID = (r_state == ST_REQ);
    assign irq_bus.oIRQ_NUM   = r_num;
    assign oPENDING           = r_pending;
    assign oOVERRUN           = r_overrun;

endmodule

// File: tb/tb_utim64_irq_scheduler.sv
// tb/tb_utim64_irq_scheduler.sv - scoreboard bench for utim64_irq_scheduler
module tb_utim64_irq_scheduler;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [3:0] src;
    logic       clr;
    logic [3:0] clr_sel;
`ifdef UTIM64_IRQ_MASK_EN
    logic       mask_wr;
    logic [3:0] mask_data;
`endif

    utim64_irq_scheduler_if #(.P_CH_W(2)) bus ();

    utim64_irq_scheduler #(.P_CH_N(4), .P_CH_W(2)) dut (
        .iCLOCK     (clk),
        .inRESET    (rst_n),
        .iSCHED_ENA (ena),
        .iIRQ_SRC   (src),
        .iCLEAR     (clr),
        .iCLEAR_SEL (clr_sel),
`ifdef UTIM64_IRQ_MASK_EN
        .iMASK_WRITE(mask_wr),
        .iMASK_DATA (mask_data),
`endif
        .irq_bus    (bus.master),
        .oPENDING   (),
        .oOVERRUN   ()
    );

    logic [3:0] pend;
    logic [3:0] ovr;
    assign pend = dut.oPENDING;
    assign ovr  = dut.oOVERRUN;

    int total = 0;
    int bad   = 0;
    int exp_q[$];
    bit auto_ack = 1'b1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) cyc(1);
        check({name, "_drain_left"}, exp_q.size(), 0);
    endtask

    // Monitor: on each falling edge, acknowledge a presented request and score its channel.
    initial begin
        int e;
        bus.iIRQ_ACK = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.oIRQ_VALID === 1'b1 && auto_ack) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_irq act=%0d exp=none t=%0t", bus.oIRQ_NUM, $time);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.oIRQ_NUM !== 2'(e)) begin
                        bad++;
                        $display("FAIL irq_order act=%0d exp=%0d t=%0t", bus.oIRQ_NUM, e, $time);
                    end
                end
                bus.iIRQ_ACK = 1'b1;
            end else begin
                bus.iIRQ_ACK = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        ena     = 1'b1;
        src     = 4'b0000;
        clr     = 1'b0;
        clr_sel = 4'b0000;
`ifdef UTIM64_IRQ_MASK_EN
        mask_wr   = 1'b0;
        mask_data = 4'b0000;
`endif
        cyc(2);
        check("rst_valid", bus.oIRQ_VALID, 0);
        check("rst_num", bus.oIRQ_NUM, 0);
        check("rst_pending", pend, 0);
        check("rst_overrun", ovr, 0);
        rst_n = 1'b1;
        cyc(1);

        // single event on channel 2
        src = 4'b0100;
        exp_q.push_back(2);
        cyc(1);
        check("t1_pending", pend, 4'b0100);
        check("t1_valid_bubble", bus.oIRQ_VALID, 0);
        cyc(1);
        check("t1_valid", bus.oIRQ_VALID, 1);
        check("t1_num", bus.oIRQ_NUM, 2);
        wait_drain("t1");
        check("t1_pending_after", pend, 0);
        check("t1_valid_after", bus.oIRQ_VALID, 0);
        src = 4'b0000;
        cyc(1);

        // round robin from reset: two rounds of all four channels
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        cyc(1);
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 4; c++) exp_q.push_back(c);
            src = 4'b1111;
            cyc(1);
            check("t2_pending_all", pend, 4'b1111);
            wait_drain("t2");
            check("t2_pending_after", pend, 0);
            src = 4'b0000;
            cyc(1);
        end

        // overrun on channel 1, then software clear of the in-flight channel
        auto_ack = 1'b0;
        src = 4'b0010;
        cyc(3);
        check("t3_valid", bus.oIRQ_VALID, 1);
        check("t3_num", bus.oIRQ_NUM, 1);
        src = 4'b0000;
        cyc(1);
        src = 4'b0010;
        cyc(1);
        check("t3_overrun", ovr, 4'b0010);
        check("t3_pending", pend, 4'b0010);
        clr = 1'b1;
        clr_sel = 4'b0010;
        cyc(1);
        clr = 1'b0;
        clr_sel = 4'b0000;
        check("t3_clr_overrun", ovr, 0);
        check("t3_clr_pending", pend, 0);
        check("t3_valid_held", bus.oIRQ_VALID, 1);
        exp_q.push_back(1);
        auto_ack = 1'b1;
        wait_drain("t3");
        check("t3_pending_after_ack", pend, 0);
        check("t3_valid_after_ack", bus.oIRQ_VALID, 0);
        src = 4'b0000;
        cyc(1);

        // request held without ack, then scheduler disabled with channel 3 pending
        auto_ack = 1'b0;
        src = 4'b0001;
        cyc(3);
        for (int i = 0; i < 20; i++) begin
            check("t4_hold_valid", bus.oIRQ_VALID, 1);
            check("t4_hold_num", bus.oIRQ_NUM, 0);
            cyc(1);
        end
        ena = 1'b0;
        src = 4'b1001;
        exp_q.push_back(0);
        auto_ack = 1'b1;
        wait_drain("t4a");
        for (int i = 0; i < 10; i++) begin
            check("t4_dis_valid", bus.oIRQ_VALID, 0);
            cyc(1);
        end
        check("t4_dis_pending", pend, 4'b1000);
        exp_q.push_back(3);
        ena = 1'b1;
        wait_drain("t4b");
        check("t4_pending_after", pend, 0);
        src = 4'b0000;
        cyc(1);

        // ack of channel 3 coincides with a new rise on channel 3
        auto_ack = 1'b0;
        src = 4'b1000;
        cyc(3);
        check("t5_valid", bus.oIRQ_VALID, 1);
        check("t5_num", bus.oIRQ_NUM, 3);
        src = 4'b0000;
        cyc(1);
        src = 4'b1000;
        exp_q.push_back(3);
        exp_q.push_back(3);
        auto_ack = 1'b1;
        cyc(1);
        check("t5_pending", pend, 4'b1000);
        check("t5_overrun", ovr, 0);
        check("t5_valid_bubble", bus.oIRQ_VALID, 0);
        wait_drain("t5");
        check("t5_pending_after", pend, 0);
        check("t5_overrun_after", ovr, 0);
        src = 4'b0000;
        cyc(1);

`ifdef UTIM64_IRQ_MASK_EN
        // channel 0 masked: only channel 1 is delivered
        mask_wr = 1'b1;
        mask_data = 4'b0001;
        cyc(1);
        mask_wr = 1'b0;
        exp_q.push_back(1);
        src = 4'b0011;
        wait_drain("t6");
        cyc(5);
        check("t6_pending", pend, 4'b0001);
        check("t6_valid_masked", bus.oIRQ_VALID, 0);
        src = 4'b0000;
        mask_wr = 1'b1;
        mask_data = 4'b0000;
        cyc(1);
        mask_wr = 1'b0;
        exp_q.push_back(0);
        wait_drain("t6b");
`endif

        // asynchronous reset in the middle of a request
        auto_ack = 1'b0;
        src = 4'b0100;
        cyc(3);
        check("t7_valid", bus.oIRQ_VALID, 1);
        check("t7_num", bus.oIRQ_NUM, 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("t7_rst_valid", bus.oIRQ_VALID, 0);
        check("t7_rst_num", bus.oIRQ_NUM, 0);
        check("t7_rst_pending", pend, 0);
        check("t7_rst_overrun", ovr, 0);
        src = 4'b0000;
        cyc(1);
        rst_n = 1'b1;
        auto_ack = 1'b1;
        cyc(5);
        check("t7_idle_after", bus.oIRQ_VALID, 0);

        check("end_queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
